// File: rtl/maxpool_relu_stage_pkg.sv
// Shared definitions for the pooling stage: default widths, int8 limits,
// FSM encodings and the HWC address helper also used by the conv stage.
package maxpool_relu_stage_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 16;

  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  // Element address in a height-width-channel laid out feature map.
  function automatic logic [31:0] hwc_addr(input logic [31:0] row, input logic [31:0] col,
                                           input logic [31:0] ch, input logic [31:0] dim,
                                           input logic [31:0] chn);
    return ch + (row * dim + col) * chn;
  endfunction

endpackage

// File: rtl/maxpool_relu_stage_if.sv
// Job handshake plus read/write memory ports of the pooling stage.
// slave = the stage itself, master = the surrounding controller and memories.
interface maxpool_relu_stage_if
  import maxpool_relu_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output start, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/maxpool_relu_stage_pool_addr_gen.sv
// Window walker for 2x2/stride-2 pooling: orow/ocol/ch/w counters, read address,
// and the output address / window index / last flag delayed to match read data.
module pool_addr_gen
  import maxpool_relu_stage_pkg::*;
#(
  parameter int DIM_IN = 32,
  parameter int CH     = 32,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              adv,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              last,
  output logic              s1_valid,
  output logic [1:0]        s1_w,
  output logic [ADDR_W-1:0] s1_oaddr,
  output logic              s1_last
);

  localparam int DIM_OUT = DIM_IN / 2;
  localparam int OW      = (DIM_OUT > 1) ? $clog2(DIM_OUT) : 1;
  localparam int CW      = (CH > 1) ? $clog2(CH) : 1;

  logic [1:0]    w;
  logic [CW-1:0] ch;
  logic [OW-1:0] ocol;
  logic [OW-1:0] orow;
  logic          ch_max;
  logic          ocol_max;
  logic          orow_max;
  logic [31:0]   row;
  logic [31:0]   col;
  logic [ADDR_W-1:0] oaddr;

  assign ch_max   = (ch == CW'(CH - 1));
  assign ocol_max = (ocol == OW'(DIM_OUT - 1));
  assign orow_max = (orow == OW'(DIM_OUT - 1));
  assign last     = ch_max && ocol_max && orow_max && (w == 2'd3);

  // w[1] selects the lower window row, w[0] the right-hand column.
  assign row     = 32'(orow) * 32'd2 + 32'(w[1]);
  assign col     = 32'(ocol) * 32'd2 + 32'(w[0]);
  assign rd_addr = ADDR_W'(hwc_addr(row, col, 32'(ch), DIM_IN, CH));
  assign oaddr   = ADDR_W'(hwc_addr(32'(orow), 32'(ocol), 32'(ch), DIM_OUT, CH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w    <= '0;
      ch   <= '0;
      ocol <= '0;
      orow <= '0;
    end else if (clear) begin
      w    <= '0;
      ch   <= '0;
      ocol <= '0;
      orow <= '0;
    end else if (adv) begin
      w <= w + 2'd1;
      if (w == 2'd3) begin
        if (ch_max) begin
          ch <= '0;
          if (ocol_max) begin
            ocol <= '0;
            orow <= orow_max ? '0 : orow + OW'(1);
          end else begin
            ocol <= ocol + OW'(1);
          end
        end else begin
          ch <= ch + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_w     <= '0;
      s1_oaddr <= '0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= adv;
      s1_w     <= w;
      s1_oaddr <= oaddr;
      s1_last  <= last;
    end
  end

endmodule

// File: rtl/maxpool_relu_stage.sv
// 2x2/stride-2 max pooling over an int8 HWC feature map, one read per clock.
// Define MAXPOOL_RELU_EN to clamp negative pooled results to zero.
module maxpool_relu_stage
  import maxpool_relu_stage_pkg::*;
#(
  parameter int DIM_IN = 32,
  parameter int CH     = 32,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  maxpool_relu_stage_if.slave   bus
);

  logic [1:0]               state;
  logic                     run;
  logic                     accept;
  logic [ADDR_W-1:0]        rd_addr_gen;
  logic                     last_rd;
  logic                     s1_valid;
  logic [1:0]               s1_w;
  logic [ADDR_W-1:0]        s1_oaddr;
  logic                     s1_last;
  logic signed [DATA_W-1:0] sample;
  logic signed [DATA_W-1:0] cur_max;
  logic signed [DATA_W-1:0] cand;
  logic signed [DATA_W-1:0] pooled;
  logic                     win_end;
  logic                     wr_en_q;
  logic [ADDR_W-1:0]        wr_addr_q;
  logic [DATA_W-1:0]        wr_data_q;
  logic                     wr_last_q;

  assign run    = (state == S_RUN);
  assign accept = (state == S_IDLE) && bus.start;

  pool_addr_gen #(
    .DIM_IN (DIM_IN),
    .CH     (CH),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .adv      (run),
    .rd_addr  (rd_addr_gen),
    .last     (last_rd),
    .s1_valid (s1_valid),
    .s1_w     (s1_w),
    .s1_oaddr (s1_oaddr),
    .s1_last  (s1_last)
  );

  assign sample  = bus.rd_data;
  assign win_end = s1_valid && (s1_w == 2'd3);

  // First window sample seeds the max; ties keep the value already held.
  always_comb begin
    cand = sample;
    if ((s1_w != 2'd0) && !(sample > cur_max))
      cand = cur_max;
  end

`ifdef MAXPOOL_RELU_EN
  assign pooled = cand[DATA_W-1] ? '0 : cand;
`else
  assign pooled = cand;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_max   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_last_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  if (bus.start) state <= S_RUN;
        S_RUN:   if (last_rd) state <= S_DRAIN;
        S_DRAIN: if (wr_en_q && wr_last_q) state <= S_FIN;
        default: state <= S_IDLE;
      endcase
      if (s1_valid)
        cur_max <= cand;
      wr_en_q   <= win_end;
      wr_last_q <= win_end && s1_last;
      if (win_end) begin
        wr_addr_q <= s1_oaddr;
        wr_data_q <= pooled;
      end
    end
  end

  assign bus.busy    = (state == S_RUN) || (state == S_DRAIN);
  assign bus.done    = (state == S_FIN);
  assign bus.rd_en   = run;
  assign bus.rd_addr = run ? rd_addr_gen : '0;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_maxpool_relu_stage.sv
// Directed bench for maxpool_relu_stage at default size (32x32x32 -> 16x16x32).
// Memory model, write monitor and a 2x2 max reference model; runs under either build.
module tb_maxpool_relu_stage;
  import maxpool_relu_stage_pkg::*;

  localparam int DIM  = 32;
  localparam int CHN  = 32;
  localparam int DO   = 16;
  localparam int NRD  = DO * DO * CHN * 4;
  localparam int NWR  = DO * DO * CHN;
  localparam int NMEM = DIM * DIM * CHN;

  logic clk;
  logic reset;

  maxpool_relu_stage_if #(.DATA_W(8), .ADDR_W(16)) bus ();

  maxpool_relu_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [7:0] mem [NMEM];
  int out_val [NWR];
  int out_job [NWR];

  int checks   = 0;
  int failures = 0;
  int job_id   = 0;

  int cyc          = 0;
  int rd_cnt       = 0;
  int wr_cnt       = 0;
  int done_cnt     = 0;
  int order_errs   = 0;
  int rd_job       = -1;
  int wr_job       = -1;
  int first_rd_cyc = 0;
  int first_wr_cyc = 0;
  int last_wr_cyc  = 0;
  int done_cyc     = 0;
  int last_wr_addr = 0;
  int last_rd_addr = 0;
  int busy_at_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus.rd_en) bus.rd_data <= mem[int'(bus.rd_addr)];

  always @(negedge clk) begin
    if (bus.rd_en) begin
      if (rd_job != job_id) begin
        rd_job       <= job_id;
        first_rd_cyc <= cyc;
      end
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= int'(bus.rd_addr);
    end
    if (bus.wr_en) begin
      if (wr_job != job_id) begin
        wr_job       <= job_id;
        first_wr_cyc <= cyc;
        if (bus.wr_addr != 16'd0) order_errs <= order_errs + 1;
      end else if (int'(bus.wr_addr) != last_wr_addr + 1) begin
        order_errs <= order_errs + 1;
      end
      last_wr_addr               <= int'(bus.wr_addr);
      last_wr_cyc                <= cyc;
      wr_cnt                     <= wr_cnt + 1;
      out_val[int'(bus.wr_addr)] <= int'($signed(bus.wr_data));
      out_job[int'(bus.wr_addr)] <= job_id;
    end
    if (bus.done) begin
      done_cnt     <= done_cnt + 1;
      done_cyc     <= cyc;
      busy_at_done <= int'(bus.busy);
    end
  end

  task automatic check_eq(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  function automatic int model(input int oaddr);
    int c, pix, orow, ocol, m, v;
    c    = oaddr % CHN;
    pix  = oaddr / CHN;
    orow = pix / DO;
    ocol = pix % DO;
    m    = -1000;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        v = int'(mem[c + ((2 * orow + dy) * DIM + 2 * ocol + dx) * CHN]);
        if (v > m) m = v;
      end
`ifdef MAXPOOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m;
  endfunction

  task automatic fill_ramp();
    for (int a = 0; a < NMEM; a++) mem[a] = 8'(a % 128);
  endtask

  task automatic fill_const(input int val);
    for (int a = 0; a < NMEM; a++) mem[a] = 8'(val);
  endtask

  task automatic verify(input string tag);
    int errs;
    errs = 0;
    for (int a = 0; a < NWR; a++)
      if (out_job[a] != job_id || out_val[a] != model(a)) errs++;
    check_eq({tag, "_model_errs"}, errs, 0);
  endtask

  // Runs one job to completion; optionally pokes start while busy and in FIN.
  task automatic run_job(input string tag, input bit poke_busy, input bit poke_fin);
    int guard;
    int rd0, wr0, done0, ord0;
    job_id++;
    rd0   = rd_cnt;
    wr0   = wr_cnt;
    done0 = done_cnt;
    ord0  = order_errs;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq({tag, "_busy_after_start"}, int'(bus.busy), 1);
    guard = 0;
    while (!bus.done && guard < 40000) begin
      bus.start = (poke_busy && guard == 100);
      @(negedge clk);
      guard++;
    end
    bus.start = 1'b0;
    check_eq({tag, "_done_seen"}, int'(guard < 40000), 1);
    if (poke_fin) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      check_eq({tag, "_fin_start_busy"}, int'(bus.busy), 0);
    end else begin
      @(negedge clk);
    end
    check_eq({tag, "_rd_count"}, rd_cnt - rd0, NRD);
    check_eq({tag, "_wr_count"}, wr_cnt - wr0, NWR);
    check_eq({tag, "_done_pulses"}, done_cnt - done0, 1);
    check_eq({tag, "_order_errs"}, order_errs - ord0, 0);
    check_eq({tag, "_first_wr_latency"}, first_wr_cyc - first_rd_cyc, 5);
    check_eq({tag, "_done_after_last_wr"}, done_cyc - last_wr_cyc, 1);
    check_eq({tag, "_busy_at_done"}, busy_at_done, 0);
    check_eq({tag, "_last_wr_addr"}, last_wr_addr, NWR - 1);
    check_eq({tag, "_last_rd_addr"}, last_rd_addr, NMEM - 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int wr0;
    int exp_neg;
    int bad;

    for (int a = 0; a < NWR; a++) begin
      out_val[a] = 0;
      out_job[a] = 0;
    end
    reset     = 1'b1;
    bus.start = 1'b0;
    fill_ramp();
    repeat (3) @(negedge clk);
    check_eq("rst_rd_en", int'(bus.rd_en), 0);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_done", int'(bus.done), 0);
    check_eq("rst_wr_en", int'(bus.wr_en), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_busy", int'(bus.busy), 0);

    // Ramp with two planted windows: ch3 {-5,7,7,-128}, ch5 {-1,5,-2,3}.
    mem[3]    = -8'sd5;
    mem[35]   = 8'sd7;
    mem[1027] = 8'sd7;
    mem[1059] = -8'sd128;
    mem[5]    = -8'sd1;
    mem[37]   = 8'sd5;
    mem[1029] = -8'sd2;
    mem[1061] = 8'sd3;
    run_job("ramp", 1'b1, 1'b1);
    check_eq("ramp_wr0", out_val[0], 32);
    check_eq("win_ch3", out_val[3], 7);
    check_eq("win_ch5_signed", out_val[5], 5);
    check_eq("ramp_wr1", out_val[1], 33);
    verify("ramp");

    // Abort around the 1000th read of a second ramp job.
    fill_ramp();
    job_id++;
    wr0 = rd_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    guard = 0;
    while (rd_cnt - wr0 < 1000 && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    check_eq("abort_reached", int'(guard < 3000), 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("abort_rd_en", int'(bus.rd_en), 0);
    check_eq("abort_rd_addr", int'(bus.rd_addr), 0);
    check_eq("abort_busy", int'(bus.busy), 0);
    check_eq("abort_done", int'(bus.done), 0);
    check_eq("abort_wr_en", int'(bus.wr_en), 0);
    check_eq("abort_wr_addr", int'(bus.wr_addr), 0);
    check_eq("abort_wr_data", int'(bus.wr_data), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wr0 = wr_cnt;
    repeat (30) @(negedge clk);
    check_eq("abort_no_wr", wr_cnt - wr0, 0);
    check_eq("abort_idle_busy", int'(bus.busy), 0);

    // Recovery job on an all -128 map.
    fill_const(INT8_MIN);
`ifdef MAXPOOL_RELU_EN
    exp_neg = 0;
`else
    exp_neg = INT8_MIN;
`endif
    run_job("neg", 1'b0, 1'b0);
    check_eq("neg_wr0", out_val[0], exp_neg);
    check_eq("neg_wr_last_raw", int'(bus.wr_data), exp_neg & 8'hFF);
    bad = 0;
    for (int a = 0; a < NWR; a++)
      if (out_job[a] != job_id || out_val[a] != exp_neg) bad++;
    check_eq("neg_all_const", bad, 0);
    verify("neg");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
